// File: rtl/rv64_alu_pkg.sv
// Shared ALU control codes and multiply/divide FSM state type.
// Decode and the execution units import this so the code map lives in one place.
package rv64_alu_pkg;

  localparam logic [3:0] ALU_AND    = 4'b0000;
  localparam logic [3:0] ALU_OR     = 4'b0001;
  localparam logic [3:0] ALU_ADD    = 4'b0010;
  localparam logic [3:0] ALU_XOR    = 4'b0011;
  localparam logic [3:0] ALU_SLL    = 4'b0100;
  localparam logic [3:0] ALU_SRL    = 4'b0101;
  localparam logic [3:0] ALU_SUB    = 4'b0110;
  localparam logic [3:0] ALU_SRA    = 4'b0111;

  // Bit 3 set selects the M extension
  localparam logic [3:0] ALU_MUL    = 4'b1000;
  localparam logic [3:0] ALU_MULH   = 4'b1001;
  localparam logic [3:0] ALU_MULHSU = 4'b1010;
  localparam logic [3:0] ALU_MULHU  = 4'b1011;
  localparam logic [3:0] ALU_DIV    = 4'b1100;
  localparam logic [3:0] ALU_DIVU   = 4'b1101;
  localparam logic [3:0] ALU_REM    = 4'b1110;
  localparam logic [3:0] ALU_REMU   = 4'b1111;

  typedef enum logic [2:0] {
    MD_IDLE,
    MD_PREP,
    MD_BUSY,
    MD_FIXUP,
    MD_DONE
  } muldiv_state_e;

endpackage

// File: rtl/rv64_muldiv_unit_step.sv
// One iteration of unsigned radix-2 shift-add multiply or restoring divide
// over a {high, low} double-width accumulator.
module muldiv_step #(
  parameter int XLEN = 64
) (
  input  logic [2*XLEN-1:0] i_acc,
  input  logic [XLEN-1:0]   i_opnd,
  input  logic              i_div,
  output logic [2*XLEN-1:0] o_acc
);

  logic [XLEN:0] w_sum;
  logic [XLEN:0] w_part;
  logic [XLEN:0] w_diff;

  always_comb begin
    // Multiply: carry out of the high half shifts back in from the top
    w_sum  = {1'b0, i_acc[2*XLEN-1:XLEN]} + (i_acc[0] ? {1'b0, i_opnd} : '0);
    // Divide: partial remainder with the next dividend bit appended
    w_part = i_acc[2*XLEN-1:XLEN-1];
    w_diff = w_part - {1'b0, i_opnd};
    if (!i_div)
      o_acc = {w_sum, i_acc[XLEN-1:1]};
    else if (!w_diff[XLEN])
      o_acc = {w_diff[XLEN-1:0], i_acc[XLEN-2:0], 1'b1};
    else
      o_acc = {w_part[XLEN-1:0], i_acc[XLEN-2:0], 1'b0};
  end

endmodule

// File: rtl/rv64_muldiv_unit.sv
// Iterative RV64 M-extension unit: magnitude prep, XLEN shift iterations,
// sign fixup, with valid/ready handshakes on both ends.
module rv64_muldiv_unit
  import rv64_alu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_valid,
  output logic            start_ready,
  input  logic [3:0]      alu_op,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            result_valid,
  input  logic            result_ready,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  muldiv_state_e    r_state;
  logic [3:0]       r_op;
  logic [XLEN-1:0]  r_a, r_b, r_opnd, r_result;
  logic [2*XLEN-1:0] r_acc;
  logic             r_neg, r_valid;
  logic [CW-1:0]    r_cnt;

  logic              w_is_div, w_is_rem, w_a_neg, w_b_neg, w_neg_res, w_div0, w_ovf;
  logic [XLEN-1:0]   w_a_mag, w_b_mag, w_special, w_quo, w_rem, w_fix;
  logic [2*XLEN-1:0] w_acc_next, w_prod;

  always_comb begin
    w_is_div  = r_op[2];
    w_is_rem  = r_op[1];
    w_a_neg   = r_a[XLEN-1] & (r_op == ALU_MULH || r_op == ALU_MULHSU ||
                               r_op == ALU_DIV  || r_op == ALU_REM);
    w_b_neg   = r_b[XLEN-1] & (r_op == ALU_MULH || r_op == ALU_DIV || r_op == ALU_REM);
    w_a_mag   = w_a_neg ? -r_a : r_a;
    w_b_mag   = w_b_neg ? -r_b : r_b;
    // Remainder follows the dividend; products and quotients follow the sign XOR
    w_neg_res = (w_is_div && w_is_rem) ? w_a_neg : (w_a_neg ^ w_b_neg);
    w_div0    = w_is_div && (r_b == '0);
    w_ovf     = (r_op == ALU_DIV || r_op == ALU_REM) &&
                (r_a == {1'b1, {(XLEN-1){1'b0}}}) && (&r_b);
    w_special = '0;
    if (r_op[3] && w_div0)
      w_special = w_is_rem ? r_a : '1;
    else if (r_op[3] && w_ovf)
      w_special = w_is_rem ? '0 : r_a;

    w_prod = r_neg ? -r_acc : r_acc;
    w_quo  = r_acc[XLEN-1:0];
    w_rem  = r_acc[2*XLEN-1:XLEN];
    if (w_is_div)
      w_fix = w_is_rem ? (r_neg ? -w_rem : w_rem) : (r_neg ? -w_quo : w_quo);
    else
      w_fix = (r_op[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
  end

  muldiv_step #(.XLEN(XLEN)) u_step (
    .i_acc  (r_acc),
    .i_opnd (r_opnd),
    .i_div  (w_is_div),
    .o_acc  (w_acc_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= MD_IDLE;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_opnd   <= '0;
      r_acc    <= '0;
      r_neg    <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
      r_valid  <= 1'b0;
    end else begin
      case (r_state)
        MD_IDLE: if (start_valid) begin
          r_op    <= alu_op;
          r_a     <= op_a;
          r_b     <= op_b;
          r_state <= MD_PREP;
        end
        MD_PREP: begin
          if (!r_op[3] || w_div0 || w_ovf) begin
            r_result <= w_special;
            r_valid  <= 1'b1;
            r_state  <= MD_DONE;
          end else begin
            // Multiply iterates over op_b bits; divide shifts op_a bits in
            r_cnt   <= '0;
            r_neg   <= w_neg_res;
            r_opnd  <= w_is_div ? w_b_mag : w_a_mag;
            r_acc   <= {{XLEN{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
            r_state <= MD_BUSY;
          end
        end
        MD_BUSY: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(XLEN-1)) r_state <= MD_FIXUP;
        end
        MD_FIXUP: begin
          r_result <= w_fix;
          r_valid  <= 1'b1;
          r_state  <= MD_DONE;
        end
        MD_DONE: if (result_ready) begin
          r_valid <= 1'b0;
          r_state <= MD_IDLE;
        end
        default: r_state <= MD_IDLE;
      endcase
    end
  end

  assign start_ready  = (r_state == MD_IDLE) && !rst;
  assign result_valid = r_valid;
  assign result       = r_result;

endmodule

// File: tb/tb_rv64_muldiv_unit.sv
// Directed bench for rv64_muldiv_unit with an arithmetic reference model and scoreboard.
module tb_rv64_muldiv_unit;
  import rv64_alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start_valid, start_ready, result_valid, result_ready;
  logic [3:0]  alu_op;
  logic [63:0] op_a, op_b, result;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  rv64_muldiv_unit #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .alu_op(alu_op), .op_a(op_a), .op_b(op_b), .result_valid(result_valid),
    .result_ready(result_ready), .result(result)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: full-width products of sign/zero-extended operands, native division
  function automatic logic [63:0] model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] sa, ua, sb, ub, p;
    logic signed [63:0] sa64, sb64;
    logic [63:0] mn;
    mn = 64'h8000_0000_0000_0000;
    sa = {{64{a[63]}}, a}; ua = {64'd0, a};
    sb = {{64{b[63]}}, b}; ub = {64'd0, b};
    sa64 = a; sb64 = b;
    case (op)
      ALU_MUL:    begin p = ua * ub; return p[63:0];   end
      ALU_MULH:   begin p = sa * sb; return p[127:64]; end
      ALU_MULHSU: begin p = sa * ub; return p[127:64]; end
      ALU_MULHU:  begin p = ua * ub; return p[127:64]; end
      ALU_DIV:    if (b == 0) return '1; else if (a == mn && b == '1) return mn; else return sa64 / sb64;
      ALU_DIVU:   if (b == 0) return '1; else return a / b;
      ALU_REM:    if (b == 0) return a;  else if (a == mn && b == '1) return 0; else return sa64 % sb64;
      ALU_REMU:   if (b == 0) return a;  else return a % b;
      default:    return 64'd0;
    endcase
  endfunction

  // Scoreboard: every cycle a result is presented it must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && result_valid) begin
      chk("start_ready_in_done", 64'(start_ready), 64'd0);
      if (exp_q.size() == 0) chk("unexpected_valid", 64'(result_valid), 64'd0);
      else begin
        chk("result", result, exp_q[0]);
        if (result_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic accept(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    int w;
    @(negedge clk);
    start_valid = 1'b1; alu_op = op; op_a = a; op_b = b;
    w = 0;
    while (!start_ready && w < 200) begin @(negedge clk); w++; end
    if (!start_ready) chk("accept_timeout", 64'(start_ready), 64'd1);
    @(posedge clk);
    exp_q.push_back(model(op, a, b));
    #1;
    start_valid = 1'b0; alu_op = ALU_ADD; op_a = ~a; op_b = ~b;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!result_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    if (!result_valid) chk("valid_timeout", 64'(result_valid), 64'd1);
  endtask

  task automatic do_op(input string name, input logic [3:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp, input bit special);
    int lat;
    chk({name, "_model"}, model(op, a, b), exp);
    accept(op, a, b);
    wait_valid(lat);
    if (special) chk({name, "_lat"}, 64'(lat >= 1 && lat <= 2), 64'd1);
    else         chk({name, "_lat"}, 64'(lat), 64'd66);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [63:0] held;
    rst = 1'b1; start_valid = 1'b0; result_ready = 1'b1;
    alu_op = '0; op_a = '0; op_b = '0;
    #12;
    chk("rst_start_ready", 64'(start_ready), 64'd0);
    chk("rst_result_valid", 64'(result_valid), 64'd0);
    chk("rst_result", result, 64'd0);
    @(negedge clk); rst = 1'b0; #1;
    chk("post_rst_start_ready", 64'(start_ready), 64'd1);

    do_op("mul_7_m3",    ALU_MUL,    64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 0);
    do_op("mulhu_ones",  ALU_MULHU,  '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 0);
    do_op("mulh_ones",   ALU_MULH,   '1, '1, 64'd0, 0);
    do_op("mulhsu_m1_2", ALU_MULHSU, '1, 64'd2, '1, 0);
    do_op("mulh_minmin", ALU_MULH,   64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, 0);
    do_op("mul_big",     ALU_MUL,    64'h0000_0001_0000_0001, 64'h0000_0001_0000_0001, 64'h0000_0002_0000_0001, 0);
    do_op("div_m7_2",    ALU_DIV,    64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 0);
    do_op("rem_m7_2",    ALU_REM,    64'hFFFF_FFFF_FFFF_FFF9, 64'd2, '1, 0);
    do_op("divu_100_7",  ALU_DIVU,   64'd100, 64'd7, 64'd14, 0);
    do_op("remu_100_7",  ALU_REMU,   64'd100, 64'd7, 64'd2, 0);
    do_op("rem_7_m2",    ALU_REM,    64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 0);
    do_op("divu_ones_3", ALU_DIVU,   '1, 64'd3, 64'h5555_5555_5555_5555, 0);
    do_op("div_5_0",     ALU_DIV,    64'd5, 64'd0, '1, 1);
    do_op("remu_5_0",    ALU_REMU,   64'd5, 64'd0, 64'd5, 1);
    do_op("rem_9_0",     ALU_REM,    64'd9, 64'd0, 64'd9, 1);
    do_op("div_ovf",     ALU_DIV,    64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1);
    do_op("rem_ovf",     ALU_REM,    64'h8000_0000_0000_0000, '1, 64'd0, 1);
    do_op("illegal",     ALU_ADD,    64'd5, 64'd6, 64'd0, 1);

    // Backpressure in DONE
    result_ready = 1'b0;
    accept(ALU_DIVU, 64'd1000, 64'd10);
    wait_valid(lat);
    chk("bp_lat", 64'(lat), 64'd66);
    held = result;
    chk("bp_value", held, 64'd100);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid_held", 64'(result_valid), 64'd1);
      chk("bp_result_held", result, held);
      chk("bp_start_ready", 64'(start_ready), 64'd0);
      if (i == 3) begin start_valid = 1'b1; alu_op = ALU_MUL; op_a = 64'd2; op_b = 64'd2; end
      if (i == 4) start_valid = 1'b0;
    end
    result_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 64'(result_valid), 64'd0);
    chk("bp_release_ready", 64'(start_ready), 64'd1);
    @(posedge clk); #1;
    chk("bp_no_stray_accept", 64'(start_ready), 64'd1);

    // Reset in BUSY
    accept(ALU_MUL, 64'd5, 64'd6);
    repeat (30) @(posedge clk);
    #2 rst = 1'b1; #1;
    chk("busy_rst_valid", 64'(result_valid), 64'd0);
    chk("busy_rst_ready", 64'(start_ready), 64'd0);
    exp_q.delete();
    @(negedge clk); rst = 1'b0; #1;
    chk("busy_rst_idle", 64'(start_ready), 64'd1);
    do_op("mul_3_4", ALU_MUL, 64'd3, 64'd4, 64'd12, 0);

    // Reset while holding a result drops valid without a clock edge
    result_ready = 1'b0;
    accept(ALU_DIV, 64'd5, 64'd0);
    wait_valid(lat);
    @(negedge clk); #1 rst = 1'b1; #1;
    chk("done_rst_valid", 64'(result_valid), 64'd0);
    chk("done_rst_result", result, 64'd0);
    exp_q.delete();
    @(negedge clk); rst = 1'b0; result_ready = 1'b1; #1;
    chk("done_rst_idle", 64'(start_ready), 64'd1);
    do_op("remu_after_rst", ALU_REMU, 64'd17, 64'd5, 64'd2, 0);

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
